// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller master port between port A
// (audio engine) and port B (secondary reader/writer). One transaction is
// granted at a time; a tag FIFO remembers which port issued each
// outstanding read so returned words are steered back to their owner.
//
// Optional feature: define SDRAM_ARB_RR_EN for round-robin tie breaking
// (last-granted port loses ties, first tie after reset goes to A).
// Without it, A always wins ties.
//
// Handshake: a requester holds X_read/X_write (with address/data stable)
// until a cycle where it owns the master port and X_waitrq is low; that
// cycle is the acceptance. Read data returns later as a one-cycle X_valid
// strobe alongside X_rdata, in issue order.
module sdram_arbiter #(
    parameter int ADDR_W   = 22,
    parameter int DATA_W   = 16,
    parameter int PEND_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              a_read,
    input  logic              a_write,
    output logic              a_waitrq,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic              b_read,
    input  logic              b_write,
    output logic              b_waitrq,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_valid,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic              m_read,
    output logic              m_write,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_valid,
    input  logic              m_waitrq,
    output logic              busy,
    output logic              err_orphan,
    output logic [1:0]        dbg_owner
);

    localparam int PTR_W = $clog2(PEND_MAX);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_t;

    owner_t owner_q, owner_d, grant;

    // Tag FIFO: 0 = read issued by A, 1 = read issued by B
    logic             tag_mem [PEND_MAX];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full, empty, push, push_tag, pop, head_tag;

    logic a_req, b_req, a_elig, b_elig;

    assign full     = (count == CNT_W'(PEND_MAX));
    assign empty    = (count == '0);
    assign a_req    = a_read | a_write;
    assign b_req    = b_read | b_write;
    // A read may only be granted while a tag slot is free; writes never need one
    assign a_elig   = a_write | (a_read & ~full);
    assign b_elig   = b_write | (b_read & ~full);
    assign head_tag = tag_mem[rd_ptr];
    assign pop      = m_valid & ~empty;

`ifdef SDRAM_ARB_RR_EN
    logic last_b;

    // Winner selection on an idle port: round-robin on ties
    always_comb begin
        grant = OWN_NONE;
        if (a_elig && b_elig) grant = last_b ? OWN_A : OWN_B;
        else if (a_elig)      grant = OWN_A;
        else if (b_elig)      grant = OWN_B;
    end

    // Remember which port was granted last; reset value lets A win the first tie
    always_ff @(posedge clk) begin
        if (reset)                                         last_b <= 1'b1;
        else if (owner_q == OWN_NONE && grant != OWN_NONE) last_b <= (grant == OWN_B);
    end
`else
    // Winner selection on an idle port: A has fixed priority
    always_comb begin
        grant = OWN_NONE;
        if (a_elig)      grant = OWN_A;
        else if (b_elig) grant = OWN_B;
    end
`endif

    // Owner register
    always_ff @(posedge clk) begin
        if (reset) owner_q <= OWN_NONE;
        else       owner_q <= owner_d;
    end

    // Next owner, master-port muxing, waitrequests and tag push
    always_comb begin
        owner_d  = owner_q;
        m_addr   = '0;
        m_wdata  = '0;
        m_read   = 1'b0;
        m_write  = 1'b0;
        a_waitrq = 1'b1;
        b_waitrq = 1'b1;
        push     = 1'b0;
        push_tag = 1'b0;
        case (owner_q)
            OWN_NONE: owner_d = grant;
            OWN_A: begin
                m_addr   = a_addr;
                m_wdata  = a_wdata;
                m_write  = a_write;
                m_read   = a_read & ~a_write;
                a_waitrq = m_waitrq;
                // Dropped request or acceptance both end the grant
                if (!a_req || !m_waitrq) owner_d = OWN_NONE;
                push     = a_req & ~m_waitrq & a_read & ~a_write;
                push_tag = 1'b0;
            end
            OWN_B: begin
                m_addr   = b_addr;
                m_wdata  = b_wdata;
                m_write  = b_write;
                m_read   = b_read & ~b_write;
                b_waitrq = m_waitrq;
                if (!b_req || !m_waitrq) owner_d = OWN_NONE;
                push     = b_req & ~m_waitrq & b_read & ~b_write;
                push_tag = 1'b1;
            end
            default: owner_d = OWN_NONE;
        endcase
    end

    // Tag storage; contents are meaningless while the count excludes them
    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= push_tag;
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Sticky error: controller returned data nobody asked for
    always_ff @(posedge clk) begin
        if (reset)                 err_orphan <= 1'b0;
        else if (m_valid && empty) err_orphan <= 1'b1;
    end

    assign a_rdata   = m_rdata;
    assign b_rdata   = m_rdata;
    assign a_valid   = pop & ~head_tag;
    assign b_valid   = pop & head_tag;
    assign busy      = (owner_q != OWN_NONE) | ~empty;
    assign dbg_owner = owner_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter (default fixed-priority build).
// Each table row is one clock cycle: inputs applied after the rising
// edge, outputs compared mid-cycle, state carried from row to row.
module tb_sdram_arbiter;

  localparam int AW = 22;
  localparam int DW = 16;
  localparam int EW = 8 + AW + DW;

  typedef struct {
    logic          ar, aw, br, bw, mwr, mv;
    logic [AW-1:0] aa, ba;
    logic [DW-1:0] ad, bd, rd;
    logic [EW-1:0] exp;
  } vec_t;

  vec_t          vecs[$];
  logic [EW-1:0] exp_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [AW-1:0] a_addr, b_addr, m_addr;
  logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata, m_wdata, m_rdata;
  logic a_read, a_write, a_waitrq, a_valid;
  logic b_read, b_write, b_waitrq, b_valid;
  logic m_read, m_write, m_valid, m_waitrq, busy, err_orphan;
  logic [1:0] dbg_owner;

  sdram_arbiter dut (
    .clk(clk), .reset(reset),
    .a_addr(a_addr), .a_wdata(a_wdata), .a_read(a_read), .a_write(a_write),
    .a_waitrq(a_waitrq), .a_rdata(a_rdata), .a_valid(a_valid),
    .b_addr(b_addr), .b_wdata(b_wdata), .b_read(b_read), .b_write(b_write),
    .b_waitrq(b_waitrq), .b_rdata(b_rdata), .b_valid(b_valid),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_read(m_read), .m_write(m_write),
    .m_rdata(m_rdata), .m_valid(m_valid), .m_waitrq(m_waitrq),
    .busy(busy), .err_orphan(err_orphan), .dbg_owner(dbg_owner)
  );

  wire [EW-1:0] act = {a_waitrq, b_waitrq, a_valid, b_valid, m_read, m_write,
                       busy, err_orphan, m_addr, m_wdata};

  // ---------------- driver tasks ----------------
  task automatic add_vec(input logic ar, aw, br, bw, mwr, mv,
                         input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                         input logic [DW-1:0] rd,
                         input logic eaw, ebw, eav, ebv, emr, emw,
                         input logic [AW-1:0] ema, input logic [DW-1:0] emd,
                         input logic eb, ee);
    vec_t v;
    v.ar = ar; v.aw = aw; v.br = br; v.bw = bw; v.mwr = mwr; v.mv = mv;
    v.aa = aa; v.ad = ad; v.ba = ba; v.bd = bd; v.rd = rd;
    v.exp = {eaw, ebw, eav, ebv, emr, emw, eb, ee, ema, emd};
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    a_read = 0; a_write = 0; a_addr = '0; a_wdata = '0;
    b_read = 0; b_write = 0; b_addr = '0; b_wdata = '0;
    m_valid = 0; m_waitrq = 0; m_rdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    logic [EW-1:0] e;
    drive_idle();
    reset = 1'b1;
    step();
    step();
    #2;
    chk("reset_state", 64'(act), 64'({8'b1100_0000, {AW{1'b0}}, {DW{1'b0}}}));
    chk("reset_owner", 64'(dbg_owner), 64'd0);
    step();
    reset = 1'b0;

    // single write
    add_vec(0,1,0,0,0,0, 22'h10,16'hBEEF,0,0,0, 1,1,0,0,0,0,0,0,0,0);
    add_vec(0,1,0,0,0,0, 22'h10,16'hBEEF,0,0,0, 0,1,0,0,0,1,22'h10,16'hBEEF,1,0);
    add_vec(0,0,0,0,0,0, 0,0,0,0,0,           1,1,0,0,0,0,0,0,0,0);
    // contention: A first, B after an arbitration cycle
    add_vec(1,0,1,0,0,0, 22'h100,0,22'h200,0,0, 1,1,0,0,0,0,0,0,0,0);
    add_vec(1,0,1,0,0,0, 22'h100,0,22'h200,0,0, 0,1,0,0,1,0,22'h100,0,1,0);
    add_vec(0,0,1,0,0,0, 22'h100,0,22'h200,0,0, 1,1,0,0,0,0,0,0,1,0);
    add_vec(0,0,1,0,0,0, 22'h100,0,22'h200,0,0, 1,0,0,0,1,0,22'h200,0,1,0);
    // read routing
    add_vec(0,0,0,0,0,1, 0,0,0,0,16'h1111, 1,1,1,0,0,0,0,0,1,0);
    add_vec(0,0,0,0,0,0, 0,0,0,0,0,        1,1,0,0,0,0,0,0,1,0);
    add_vec(0,0,0,0,0,1, 0,0,0,0,16'h2222, 1,1,0,1,0,0,0,0,1,0);
    add_vec(0,0,0,0,0,0, 0,0,0,0,0,        1,1,0,0,0,0,0,0,0,0);
    // fill the tag FIFO with four A reads
    for (int k = 0; k < 4; k++) begin
      add_vec(1,0,0,0,0,0, 22'h300,0,0,0,0, 1,1,0,0,0,0,0,0,(k > 0),0);
      add_vec(1,0,0,0,0,0, 22'h300,0,0,0,0, 0,1,0,0,1,0,22'h300,0,1,0);
    end
    // full: B write passes, A read held until a slot frees
    add_vec(1,0,0,1,0,0, 22'h300,0,22'h400,16'h5A5A,0, 1,1,0,0,0,0,0,0,1,0);
    add_vec(1,0,0,1,0,0, 22'h300,0,22'h400,16'h5A5A,0, 1,0,0,0,0,1,22'h400,16'h5A5A,1,0);
    add_vec(1,0,0,0,0,0, 22'h300,0,0,0,0,          1,1,0,0,0,0,0,0,1,0);
    add_vec(1,0,0,0,0,1, 22'h300,0,0,0,16'h0AAA,   1,1,1,0,0,0,0,0,1,0);
    add_vec(1,0,0,0,0,0, 22'h300,0,0,0,0,          1,1,0,0,0,0,0,0,1,0);
    add_vec(1,0,0,0,0,0, 22'h300,0,0,0,0,          0,1,0,0,1,0,22'h300,0,1,0);
    add_vec(0,0,0,0,0,0, 0,0,0,0,0,                1,1,0,0,0,0,0,0,1,0);
    // drain all four (all tagged A)
    for (int k = 0; k < 4; k++)
      add_vec(0,0,0,0,0,1, 0,0,0,0,16'(k + 1), 1,1,1,0,0,0,0,0,1,0);
    // waitrequest stall: A read held five cycles, no push until accepted
    add_vec(1,0,1,0,1,0, 22'h500,0,22'h200,0,0, 1,1,0,0,0,0,0,0,0,0);
    for (int k = 0; k < 5; k++)
      add_vec(1,0,1,0,1,0, 22'h500,0,22'h200,0,0, 1,1,0,0,1,0,22'h500,0,1,0);
    add_vec(1,0,1,0,0,0, 22'h500,0,22'h200,0,0, 0,1,0,0,1,0,22'h500,0,1,0);
    add_vec(0,0,1,0,0,0, 0,0,22'h200,0,0,       1,1,0,0,0,0,0,0,1,0);
    add_vec(0,0,1,0,0,0, 0,0,22'h200,0,0,       1,0,0,0,1,0,22'h200,0,1,0);
    add_vec(0,0,0,0,0,1, 0,0,0,0,16'h3333,      1,1,1,0,0,0,0,0,1,0);
    add_vec(0,0,0,0,0,1, 0,0,0,0,16'h4444,      1,1,0,1,0,0,0,0,1,0);
    add_vec(0,0,0,0,0,0, 0,0,0,0,0,             1,1,0,0,0,0,0,0,0,0);
    // owner drops its request while stalled
    add_vec(0,1,0,0,1,0, 22'h30,16'h7777,0,0,0, 1,1,0,0,0,0,0,0,0,0);
    add_vec(0,1,0,0,1,0, 22'h30,16'h7777,0,0,0, 1,1,0,0,0,1,22'h30,16'h7777,1,0);
    add_vec(0,0,0,0,1,0, 22'h30,16'h7777,0,0,0, 1,1,0,0,0,0,22'h30,16'h7777,1,0);
    add_vec(0,0,0,0,0,0, 22'h30,16'h7777,0,0,0, 1,1,0,0,0,0,0,0,0,0);
    // orphan return
    add_vec(0,0,0,0,0,1, 0,0,0,0,16'h5555, 1,1,0,0,0,0,0,0,0,0);
    add_vec(0,0,0,0,0,0, 0,0,0,0,0,        1,1,0,0,0,0,0,0,0,1);

    foreach (vecs[i]) begin
      a_read = vecs[i].ar; a_write = vecs[i].aw; a_addr = vecs[i].aa; a_wdata = vecs[i].ad;
      b_read = vecs[i].br; b_write = vecs[i].bw; b_addr = vecs[i].ba; b_wdata = vecs[i].bd;
      m_waitrq = vecs[i].mwr; m_valid = vecs[i].mv; m_rdata = vecs[i].rd;
      exp_q.push_back(vecs[i].exp);
      #2;
      e = exp_q.pop_front();
      chk($sformatf("row%0d", i), 64'(act), 64'(e));
      chk($sformatf("row%0d_rdata", i), {32'(a_rdata), 32'(b_rdata)},
          {32'(vecs[i].rd), 32'(vecs[i].rd)});
      step();
    end

    // reset clears the sticky error
    drive_idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #2;
    chk("post_reset", 64'({a_waitrq, b_waitrq, busy, err_orphan, m_read, m_write}), 64'b110000);

    // two A reads outstanding, then reset while A owns a third
    a_read = 1'b1; a_addr = 22'h600;
    for (int k = 0; k < 5; k++) step();
    reset = 1'b1;
    #2;
    chk("pre_reset_owner", 64'({m_read, a_waitrq, busy}), 64'b101);
    step();
    reset = 1'b0;
    a_read = 1'b0;
    #2;
    chk("mid_reset_clear", 64'({m_read, busy, err_orphan, a_waitrq}), 64'b0001);
    for (int k = 0; k < 2; k++) begin
      step();
      m_valid = 1'b1; m_rdata = 16'(16'hC0 + k);
      #2;
      chk($sformatf("stale_ret%0d", k), 64'({a_valid, b_valid}), 64'b00);
    end
    step();
    m_valid = 1'b0;
    #2;
    chk("orphan_flag", 64'({err_orphan, busy}), 64'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port arbiter that shares the single SDRAM controller master port (address/read/write/waitrequest/valid handshake) between the audio record/playback engine (port A) and a secondary reader/writer such as the waveform display (port B). It grants one transaction at a time and tracks outstanding reads so each returned word reaches the requester that issued it. It sits between the requesters and the `sdram` controller on the 50 MHz system clock.

## Interface
Parameters:
- ADDR_W, 22, word address width (matches SDRAM controller)
- DATA_W, 16, data width
- PEND_MAX, 4, max outstanding reads tracked (power of two, ≥2)

Ports:
- clk  in  1  system clock (50 MHz); one clock domain
- reset  in  1  synchronous, active-high
- a_addr / b_addr  in  ADDR_W  requester address
- a_wdata / b_wdata  in  DATA_W  write data
- a_read / b_read  in  1  read request, held until accepted
- a_write / b_write  in  1  write request, held until accepted
- a_waitrq / b_waitrq  out  1  request not yet accepted
- a_rdata / b_rdata  out  DATA_W  read return data
- a_valid / b_valid  out  1  read return strobe, one cycle per word
- m_addr  out  ADDR_W  to controller address
- m_wdata  out  DATA_W  to controller write data
- m_read / m_write  out  1  to controller
- m_rdata  in  DATA_W  controller read data
- m_valid  in  1  controller read data valid
- m_waitrq  in  1  controller waitrequest
- busy  out  1  owner≠NONE or reads outstanding
- err_orphan  out  1  sticky: m_valid seen with no outstanding read

## Operation
- Owner register: NONE, A, B.
- Request of X = X_read | X_write. X_write with X_read both high: treated as write; read ignored.
- NONE: if any eligible request, select winner; owner ← winner at next edge. A read request is eligible only if tag FIFO not full; writes always eligible.
- Fixed priority (default): A beats B.
- Owner X: m_addr/m_wdata/m_read/m_write driven from X; X_waitrq = m_waitrq; other port waitrq = 1.
- Acceptance: owner X request high and m_waitrq low. On acceptance owner ← NONE; if read, push tag X into FIFO.
- Non-owner with request pending: waitrq = 1. Non-requesting port: waitrq = 1 (don't care).
- Owner X drops request before acceptance (protocol violation): owner ← NONE next edge, no push.
- Read return: on m_valid, pop FIFO head; head tag T gets T_valid = 1 same cycle; both X_rdata = m_rdata continuously.
- m_valid with FIFO empty: no valid to either port; err_orphan ← 1 until reset.
- Push and pop in same cycle: count unchanged, order preserved; allowed when full (pop frees slot).
- busy = (owner≠NONE) | (count≠0).

## Timing
- Reset: owner NONE, FIFO empty, m_read = m_write = 0, m_addr = m_wdata = 0, a_waitrq = b_waitrq = 1, a_valid = b_valid = 0, busy = 0, err_orphan = 0.
- Grant latency: request at cycle n with owner NONE → forwarded on m_* at n+1.
- One transaction per grant; minimum 2 cycles per transaction with m_waitrq low (one NONE arbitration cycle).
- Return path combinational: X_valid in same cycle as m_valid, zero added latency.
- m_* outputs 0 whenever owner NONE.
- Reset mid-transaction: all state cleared at that edge; later returns from the controller set err_orphan.

## Configuration
- SDRAM_ARB_RR_EN defined: round-robin; last-granted port loses ties; first tie after reset goes to A.
- Undefined: fixed priority, A always wins ties.

## Test plan
- Single write: a_write=1, a_addr=0x000010, a_wdata=0xBEEF, m_waitrq=0 → m_write=1 with 0x000010/0xBEEF one cycle later; a_waitrq low that cycle; b_waitrq stays 1.
- Contention: a_read and b_read both held from cycle 0, m_waitrq=0 → fixed: A forwarded cycle 1, B cycle 3; with SDRAM_ARB_RR_EN second simultaneous pair goes B first.
- Read routing: A reads 0x100, B reads 0x200, controller returns 0x1111 then 0x2222 → a_valid with 0x1111, then b_valid with 0x2222; never crossed.
- FIFO full: 4 reads outstanding, a_read pending, b_write pending → B write granted, A held (a_waitrq=1) until one m_valid; then A granted.
- Waitrequest stall: m_waitrq=1 for 5 cycles while A owns → m_read held stable 5 cycles, b_waitrq=1, no push until m_waitrq falls.
- Orphan/reset: reset asserted with 2 reads outstanding, then two m_valid pulses → no a_valid/b_valid, err_orphan=1, busy=0.
